// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch stage.
// Holds the address/data word types, the buffered fetch entry, the derived
// fetch states and a word-alignment helper used by fetch_unit and fetch_fifo.
package fetch_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    // One buffered instruction: the address it was fetched from plus the word.
    typedef struct packed {
        addr_t pc;
        data_t inst;
    } fetch_entry_t;

    // Default first fetch address after reset.
    localparam addr_t FETCH_RESET_PC = 32'h0000_0000;

    // Clearing the two low bits forces any address onto a word boundary.
    localparam addr_t ADDR_WORD_MASK = 32'hFFFF_FFFC;

    // Fetch stage condition, derived from reset and the drop counter:
    // IDLE_RESET right after reset, RUN in normal operation, DRAIN while
    // stale responses from before a redirect are still expected.
    typedef enum logic [1:0] {
        IDLE_RESET,
        RUN,
        DRAIN
    } fetch_state_e;

    // Word-align an address by forcing its two low bits to zero.
    function automatic addr_t align_word(input addr_t addr);
        return addr & ADDR_WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small circular buffer of fetched instructions (pc, word).
// Supports push, pop and flush. A push and a pop in the same cycle are
// accepted even when the buffer is full. Flush empties the buffer and
// overrides any push or pop in that cycle. Entries reset to RESET_ENTRY,
// so the head output is well defined while the buffer is empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int           DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = '0,
    localparam int          PTR_W       = $clog2(DEPTH),
    localparam int          CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    output logic             valid_o,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Decide which operations take effect and compute next pointers and
    // count. A pop frees a slot in the same cycle, so push-when-full works
    // together with a pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_COUNT) || do_pop);

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            do_push  = 1'b0;
            do_pop   = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Register the pointers, the count and the storage array.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decode/execute sequencer.
// Owns the fetch PC, issues in-order word reads through a request/grant
// handshake and buffers returned words with their PCs in fetch_fifo.
// Reads are credited so that outstanding + buffered + to-be-dropped never
// exceeds BUF_DEPTH. A redirect flushes the buffer and turns every
// in-flight read into a response that is silently dropped.
// Optional feature: define FETCH_PERF_EN to add the o_stall_count output,
// a saturating count of non-reset cycles with no valid instruction.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter addr_t RESET_PC  = FETCH_RESET_PC,
    parameter int    BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_mem_req,
    output addr_t       o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  data_t       i_mem_rdata,
    output logic        o_inst_valid,
    output addr_t       o_pc,
    output data_t       o_inst,
    input  logic        i_inst_take,
    input  logic        i_redirect,
    input  addr_t       i_redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_stall_count
`endif
);

    localparam int                 CNT_W        = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W+1:0]   CREDIT_LIMIT = (CNT_W+2)'(BUF_DEPTH);
    localparam fetch_entry_t       RESET_ENTRY  = '{pc: RESET_PC, inst: '0};

    fetch_state_e     state_q, state_d;
    addr_t            fetch_pc_q, fetch_pc_d;
    addr_t            shadow_pc_q, shadow_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W+1:0] inflight;
    logic             mem_req;
    logic             grant;
    logic             resp_accept;
    logic             resp_discard;
    logic             fifo_push;
    logic             fifo_pop;
    logic             inst_valid;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;

    // Credit check, handshake decode and next-state for the fetch PC, the
    // shadow PC that tags returned words, and the outstanding/drop counters.
    // A redirect overrides everything: it retargets both PCs and moves every
    // read still in flight into the drop counter.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        shadow_pc_d   = shadow_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;

        inflight = (CNT_W+2)'(outstanding_q) + (CNT_W+2)'(occupancy)
                 + (CNT_W+2)'(drop_q);
        mem_req  = !i_reset && !i_redirect && (inflight < CREDIT_LIMIT);
        grant    = mem_req && i_mem_gnt;

        // While draining, every response belongs to a pre-redirect read.
        // Outside of draining, a response only counts if a read is actually
        // outstanding; anything else is left over from before a reset.
        resp_discard = i_mem_rvalid && (state_q == DRAIN);
        resp_accept  = i_mem_rvalid && (state_q != DRAIN) && (outstanding_q != '0);

        if (i_redirect) begin
            fetch_pc_d    = align_word(i_redirect_pc);
            shadow_pc_d   = align_word(i_redirect_pc);
            outstanding_d = '0;
            drop_d        = drop_q + outstanding_q;
            if (resp_discard || resp_accept) begin
                drop_d = drop_q + outstanding_q - CNT_W'(1);
            end
        end else begin
            fifo_push = resp_accept;
            fifo_pop  = i_inst_take;
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_accept) begin
                shadow_pc_d = shadow_pc_q + 32'd4;
            end
            case ({grant, resp_accept})
                2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
                2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
                default: outstanding_d = outstanding_q;
            endcase
            if (resp_discard) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    // Derive the fetch state from the upcoming drop count so that DRAIN is
    // registered in lock-step with a non-zero drop counter.
    always_comb begin
        state_d = RUN;
        if (i_reset) begin
            state_d = IDLE_RESET;
        end else if (drop_d != '0) begin
            state_d = DRAIN;
        end
    end

    // Register the fetch PCs, counters and state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE_RESET;
            fetch_pc_q    <= RESET_PC;
            shadow_pc_q   <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            shadow_pc_q   <= shadow_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    assign push_entry = '{pc: shadow_pc_q, inst: i_mem_rdata};

    fetch_fifo #(
        .DEPTH       (BUF_DEPTH),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_fifo (
        .clk_i        (i_clk),
        .reset_i      (i_reset),
        .flush_i      (i_redirect),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .valid_o      (inst_valid),
        .head_o       (head_entry),
        .count_o      (occupancy)
    );

    assign o_mem_req    = mem_req;
    assign o_mem_addr   = fetch_pc_q;
    assign o_inst_valid = inst_valid;
    assign o_pc         = head_entry.pc;
    assign o_inst       = head_entry.inst;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Count cycles where the sequencer has nothing to consume, saturating.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!inst_valid && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Register the stall counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign o_stall_count = stall_count_q;
`endif

endmodule
